// File: rtl/ram_loader_if.sv
// Byte-stream input and shared IRAM/DRAM write port of the program loader.
`timescale 1ns/1ps
interface ram_loader_if #(
   parameter int unsigned XLEN = 32
);
   logic [7:0]      rx_data_i;
   logic            rx_valid_i;
   logic            iram_wr_en_o;
   logic            dram_wr_en_o;
   logic [XLEN-1:0] ram_wr_addr_o;
   logic [XLEN-1:0] ram_wr_data_o;
   logic [3:0]      ram_wr_byte_en_o;

   modport master (
      input  rx_data_i, rx_valid_i,
      output iram_wr_en_o, dram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o
   );

   modport slave (
      output rx_data_i, rx_valid_i,
      input  iram_wr_en_o, dram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o
   );
endinterface

// File: rtl/ram_loader.sv
// Program loader: parses HDR/LEN/DATA byte frames into RAM word writes and owns the core reset.
`timescale 1ns/1ps
module ram_loader #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned IRAM_WORDS     = 4096,
   parameter int unsigned DRAM_WORDS     = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   ram_loader_if.master bus,
   output logic         cpu_rst_n_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA} state_t;
   typedef enum logic {TGT_IRAM, TGT_DRAM} target_t;

   state_t          state_q, state_d;
   target_t         target_q, target_d;
   logic [23:0]     shift_q, shift_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [31:0]     len_q, len_d;
   logic [31:0]     idx_q, idx_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic            iram_we_q, iram_we_d;
   logic            dram_we_q, dram_we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [3:0]      be_q, be_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            cpu_rst_n_q, cpu_rst_n_d;

   logic [31:0]     word;
   logic [31:0]     depth;

   // Three previously captured bytes plus the incoming one, LSB first.
   assign word  = {bus.rx_data_i, shift_q};
   assign depth = (target_q == TGT_IRAM) ? 32'(IRAM_WORDS) : 32'(DRAM_WORDS);

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      shift_d     = shift_q;
      byte_cnt_d  = byte_cnt_q;
      len_d       = len_q;
      idx_d       = idx_q;
      idle_d      = idle_q;
      iram_we_d   = 1'b0;
      dram_we_d   = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      be_d        = 4'h0;
      done_d      = 1'b0;
      err_d       = err_q;
      cpu_rst_n_d = cpu_rst_n_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid_i) begin
               unique case (bus.rx_data_i)
                  8'h01, 8'h02: begin
                     target_d    = (bus.rx_data_i == 8'h01) ? TGT_IRAM : TGT_DRAM;
                     cpu_rst_n_d = 1'b0;
                     err_d       = 1'b0;
                     byte_cnt_d  = '0;
                     idle_d      = '0;
                     state_d     = ST_LEN;
                  end
                  8'h03:   cpu_rst_n_d = 1'b1;
                  8'h04:   cpu_rst_n_d = 1'b0;
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_LEN, ST_DATA: begin
            if (bus.rx_valid_i) begin
               idle_d     = '0;
               shift_d    = word[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (state_q == ST_LEN) begin
                     if (word == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end else if (word > depth) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                     end else begin
                        len_d   = word;
                        idx_d   = '0;
                        state_d = ST_DATA;
                     end
                  end else begin
                     iram_we_d = (target_q == TGT_IRAM);
                     dram_we_d = (target_q == TGT_DRAM);
                     addr_d    = XLEN'({idx_q, 2'b00});
                     data_d    = XLEN'(word);
                     be_d      = 4'hF;
                     idx_d     = idx_q + 32'd1;
                     if (idx_q + 32'd1 == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end
               end
            end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d      = 1'b1;
               byte_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         target_q    <= TGT_IRAM;
         shift_q     <= '0;
         byte_cnt_q  <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         idle_q      <= '0;
         iram_we_q   <= 1'b0;
         dram_we_q   <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         be_q        <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         shift_q     <= shift_d;
         byte_cnt_q  <= byte_cnt_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         idle_q      <= idle_d;
         iram_we_q   <= iram_we_d;
         dram_we_q   <= dram_we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         be_q        <= be_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   assign bus.iram_wr_en_o     = iram_we_q;
   assign bus.dram_wr_en_o     = dram_we_q;
   assign bus.ram_wr_addr_o    = addr_q;
   assign bus.ram_wr_data_o    = data_q;
   assign bus.ram_wr_byte_en_o = be_q;
   assign cpu_rst_n_o          = cpu_rst_n_q;
   assign busy_o               = (state_q != ST_IDLE);
   assign done_o               = done_q;
   assign err_o                = err_q;
endmodule
